resta_serial: RTL and testbench
===============================

RESTA_SERIAL -- requirements
Module: resta_serial

Interface
REQ-001 Parameter: PwrC, default 0, power-characterisation tag only; SHALL have no functional effect.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand set a/b/bi is valid.
REQ-005 Port: in_ready  output  1  block accepts operands; SHALL be high only in IDLE.
REQ-006 Port: a  input  8  minuend, unsigned / two's complement.
REQ-007 Port: b  input  8  subtrahend.
REQ-008 Port: bi  input  1  borrow in.
REQ-009 Port: d  output  8  difference a-b-bi mod 256, registered.
REQ-010 Port: bo  output  1  borrow out, registered; 1 when a < b+bi, unsigned.
REQ-011 Port: out_valid  output  1  d/bo (and ovf) hold a completed result.
REQ-012 Port: out_ready  input  1  consumer takes the result.

Function
REQ-013 FSM states: IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: in_valid=1 at a clock edge SHALL latch a, b and bi, clear the bit counter to 0, load the borrow register with bi, and move to CALC.
REQ-015 CALC: each cycle SHALL process bit i = counter, LSB first: diff = a[i]^b[i]^br, br_next = (~a[i]&b[i]) | (~(a[i]^b[i])&br).
REQ-016 The diff bit SHALL be stored so d[i] is bit i of the difference; bit order reversal is forbidden.
REQ-017 After bit 7 is processed the counter SHALL stop without wrapping, bo SHALL take the final borrow, and the FSM SHALL move to DONE.
REQ-018 Latency: out_valid SHALL rise exactly 8 clock edges after the accepting edge, and be high during the 9th cycle after acceptance.
REQ-019 DONE: out_valid=1; d, bo and ovf SHALL stay stable until out_ready=1 at an edge, which returns the FSM to IDLE.
REQ-020 in_valid SHALL be ignored in CALC and DONE; there is no overlap of operations, so at most 1 operation is in flight.
REQ-021 d SHALL keep the last result through IDLE and change only during CALC.
REQ-022 out_valid SHALL be low in IDLE and CALC.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE from any state, including mid-CALC; the partial result SHALL be discarded.
REQ-024 Post-reset values: d=0x00, bo=0, out_valid=0, ovf=0, counter=0, borrow register=0, in_ready=1.
REQ-025 reset SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-026 Macro RESTA_SERIAL_OVF_EN defined: the block SHALL add port ovf  output  1, registered at the same edge as bo.
REQ-027 With the macro defined, ovf SHALL equal (a[7]!=b[7]) & (d[7]!=a[7]), which is signed two's-complement overflow.
REQ-028 Macro undefined: port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 a=0x05, b=0x03, bi=0 -> out_valid 8 edges after acceptance, d=0x02, bo=0.
REQ-030 a=0x00, b=0x01, bi=0 -> d=0xFF, bo=1.
REQ-031 a=0x10, b=0x10, bi=1 -> d=0xFF, bo=1.
REQ-032 With RESTA_SERIAL_OVF_EN: a=0x80, b=0x01, bi=0 -> d=0x7F, bo=0, ovf=1.
REQ-033 reset pulsed while counter=4 in CALC -> next cycle IDLE, in_ready=1, out_valid=0, d=0x00; a new operation then completes correctly.
REQ-034 out_ready held low 5 cycles in DONE with in_valid=1 and new a/b applied -> d/bo unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.

Source files
------------

// File: rtl/resta_serial.sv
// resta_serial: bit-serial 8-bit subtractor, d = a - b - bi (mod 256), LSB first.
// One operand set is accepted in IDLE, one bit is resolved per clock in CALC,
// and the result is held in DONE until the consumer takes it.
// The optional signed-overflow output ovf is built only when the macro
// RESTA_SERIAL_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high, last result still on d
// CALC  | one difference bit per cycle, bit index = cnt
// DONE  | result valid; held until out_ready
module resta_serial #(
    parameter int PwrC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bi,
    output logic [7:0] d,
    output logic       bo,
`ifdef RESTA_SERIAL_OVF_EN
    output logic       ovf,
`endif
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [2:0] cnt;
    logic       br;

    logic       a_bit;
    logic       b_bit;
    logic       diff_bit;
    logic       br_next;

    // Full-subtractor cell for the bit currently selected by the counter.
    always_comb begin
        a_bit    = a_q[cnt];
        b_bit    = b_q[cnt];
        diff_bit = a_bit ^ b_bit ^ br;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    // Sequencer: operand capture, per-bit datapath update and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            cnt       <= 3'd0;
            br        <= 1'b0;
            d         <= 8'h00;
            bo        <= 1'b0;
`ifdef RESTA_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        br       <= bi;
                        cnt      <= 3'd0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    d[cnt] <= diff_bit;
                    br     <= br_next;
                    if (cnt == 3'd7) begin
                        // Counter parks at 7; the final borrow becomes bo.
                        bo        <= br_next;
`ifdef RESTA_SERIAL_OVF_EN
                        ovf       <= (a_q[7] ^ b_q[7]) & (diff_bit ^ a_q[7]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resta_serial.sv
// Directed self-checking bench for resta_serial.
module tb_resta_serial;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
`ifdef RESTA_SERIAL_OVF_EN
    logic       ovf;
`endif
    logic       out_valid;
    logic       out_ready;

    int tests = 0;
    int fails = 0;

    resta_serial #(.PwrC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .d         (d),
        .bo        (bo),
`ifdef RESTA_SERIAL_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one operation; hold out_ready low for 'hold' cycles in DONE while
    // presenting fresh operands with in_valid high, then release.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tbi, input logic [7:0] ed, input logic ebo,
                         input logic eovf, input int hold);
        a = ta; b = tb_; bi = tbi; in_valid = 1'b1;
        step();                              // accepting edge
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        // Operands changing mid-calculation must not matter.
        a = ~ta; b = ~tb_; bi = ~tbi; in_valid = 1'b1;
        repeat (7) step();
        chk({tag, "_ov_lat7"}, {31'd0, out_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        chk({tag, "_ov_lat8"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_d"}, {24'd0, d}, {24'd0, ed});
        chk({tag, "_bo"}, {31'd0, bo}, {31'd0, ebo});
`ifdef RESTA_SERIAL_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
        if (eovf) begin end
`endif
        for (int i = 0; i < hold; i++) begin
            a = 8'h3C; b = 8'hC3; bi = 1'b1; in_valid = 1'b1;
            step();
            chk({tag, "_hold_d"}, {24'd0, d}, {24'd0, ed});
            chk({tag, "_hold_bo"}, {31'd0, bo}, {31'd0, ebo});
            chk({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_hold_ov"}, {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_ov"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle_d"}, {24'd0, d}, {24'd0, ed});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; bi = 1'b0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_d", {24'd0, d}, 32'd0);
        chk("rst_bo", {31'd0, bo}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
`ifdef RESTA_SERIAL_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

        do_op("v05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
        do_op("v00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        do_op("v10m10b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        do_op("v80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
        do_op("vA5m5A", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 0);
        do_op("v7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
        do_op("v00mFFb", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        do_op("vFFm00b", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 0);

        // Reset while cnt=4 in CALC: back to IDLE with partial result dropped.
        a = 8'h05; b = 8'h03; bi = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
        chk("midrst_ov", {31'd0, out_valid}, 32'd0);
        chk("midrst_d", {24'd0, d}, 32'd0);
        chk("midrst_bo", {31'd0, bo}, 32'd0);
        do_op("after_rst", 8'h37, 8'h12, 1'b1, 8'h24, 1'b0, 1'b0, 0);

        // Reset wins over in_valid in IDLE.
        a = 8'h09; b = 8'h01; bi = 1'b0; in_valid = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("rstprio_rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk("rstprio_still_idle", {31'd0, in_ready}, 32'd1);

        // Back-pressure in DONE for 5 cycles with new operands offered.
        do_op("hold5", 8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
